// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage: decodes OP, OP-IMM and LUI into an ALU bundle and
// hands it downstream through a two-entry skid buffer with a registered in_ready.
module alu_decode_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      src1,
    output logic [31:0]      src2,
    output logic [5:0]       alu_control,
    output logic [4:0]       shamt,
    output logic [4:0]       rd,
    output logic             rd_we,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [5:0] ALU_NOP  = 6'd0;
    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_SLL  = 6'd3;
    localparam logic [5:0] ALU_SLT  = 6'd4;
    localparam logic [5:0] ALU_OR   = 6'd5;
    localparam logic [5:0] ALU_XOR  = 6'd6;
    localparam logic [5:0] ALU_SRL  = 6'd7;
    localparam logic [5:0] ALU_AND  = 6'd8;
    localparam logic [5:0] ALU_SRA  = 6'd9;
    localparam logic [5:0] ALU_SLTU = 6'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [5:0]  alu_control;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic bundle_t decode(input logic [31:0] ins,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        bundle_t    d;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [5:0] op_code;
        logic       ok;
        d       = '0;
        f7      = ins[31:25];
        f3      = ins[14:12];
        op_code = ALU_NOP;
        ok      = 1'b1;
        case (ins[6:0])
            OPC_OP: begin
                d.src1  = a;
                d.src2  = b;
                d.shamt = b[4:0];
                case (f3)
                    3'b000: begin
                        if (f7 == F7_BASE)     op_code = ALU_ADD;
                        else if (f7 == F7_ALT) op_code = ALU_SUB;
                        else                   ok = 1'b0;
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)     op_code = ALU_SRL;
                        else if (f7 == F7_ALT) op_code = ALU_SRA;
                        else                   ok = 1'b0;
                    end
                    default: begin
                        if (f7 != F7_BASE) ok = 1'b0;
                        else               ok = 1'b1;
                        case (f3)
                            3'b001:  op_code = ALU_SLL;
                            3'b010:  op_code = ALU_SLT;
                            3'b011:  op_code = ALU_SLTU;
                            3'b100:  op_code = ALU_XOR;
                            3'b110:  op_code = ALU_OR;
                            3'b111:  op_code = ALU_AND;
                            default: ok = 1'b0;
                        endcase
                    end
                endcase
            end
            OPC_OP_IMM: begin
                d.src1 = a;
                d.src2 = {{20{ins[31]}}, ins[31:20]};
                case (f3)
                    3'b000: op_code = ALU_ADD;
                    3'b010: op_code = ALU_SLT;
                    3'b011: op_code = ALU_SLTU;
                    3'b100: op_code = ALU_XOR;
                    3'b110: op_code = ALU_OR;
                    3'b111: op_code = ALU_AND;
                    3'b001: begin
                        if (f7 == F7_BASE) op_code = ALU_SLL;
                        else               ok = 1'b0;
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)     op_code = ALU_SRL;
                        else if (f7 == F7_ALT) op_code = ALU_SRA;
                        else                   ok = 1'b0;
                    end
                    default: ok = 1'b0;
                endcase
                // Immediate shifts carry the 5-bit amount on both shamt and src2.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.shamt = ins[24:20];
                    d.src2  = {27'd0, ins[24:20]};
                end else begin
                    d.shamt = 5'd0;
                end
            end
            OPC_LUI: begin
                d.src1  = 32'd0;
                d.src2  = {ins[31:12], 12'd0};
                op_code = ALU_ADD;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) d = '0;
        else     d.alu_control = op_code;
        d.rd      = ins[11:7];
        d.illegal = ~ok;
        d.rd_we   = ok && (ins[11:7] != 5'd0);
        return d;
    endfunction

    state_t   state_r, state_s;
    bundle_t  dec_s, out_r, skid_r;
    logic     out_valid_r, in_ready_r;
    logic     accept_s, drain_s;
    logic     load_out_s, load_skid_s, pop_skid_s;
    logic [CNT_W-1:0] illegal_cnt_r;

    assign dec_s    = decode(instr, rs1_data, rs2_data);
    assign accept_s = in_valid && in_ready_r;
    assign drain_s  = out_valid_r && out_ready;

    // Skid-buffer next-state and datapath load selection.
    always_comb begin
        state_s     = state_r;
        load_out_s  = 1'b0;
        load_skid_s = 1'b0;
        pop_skid_s  = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    load_out_s = 1'b1;
                    state_s    = ST_BUSY;
                end else begin
                    state_s    = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (accept_s && drain_s) begin
                    load_out_s  = 1'b1;
                    state_s     = ST_BUSY;
                end else if (accept_s) begin
                    load_skid_s = 1'b1;
                    state_s     = ST_FULL;
                end else if (drain_s) begin
                    state_s     = ST_EMPTY;
                end else begin
                    state_s     = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    pop_skid_s = 1'b1;
                    state_s    = ST_BUSY;
                end else begin
                    state_s    = ST_FULL;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // State plus the registered handshake flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_EMPTY);
            in_ready_r  <= (state_s != ST_FULL);
        end
    end

    // Output and skid bundle registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r  <= '0;
            skid_r <= '0;
        end else begin
            if (load_out_s)      out_r <= dec_s;
            else if (pop_skid_s) out_r <= skid_r;
            if (load_skid_s)     skid_r <= dec_s;
        end
    end

    // Saturating count of accepted illegal bundles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt_r <= '0;
        end else if (accept_s && dec_s.illegal && (illegal_cnt_r != CNT_MAX)) begin
            illegal_cnt_r <= illegal_cnt_r + CNT_ONE;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign src1        = out_r.src1;
    assign src2        = out_r.src2;
    assign alu_control = out_r.alu_control;
    assign shamt       = out_r.shamt;
    assign rd          = out_r.rd;
    assign rd_we       = out_r.rd_we;
    assign illegal     = out_r.illegal;
    assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed table-driven bench for alu_decode_stage, with hand-written
// sequences for saturation, backpressure and reset while full.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;

    logic        in_ready, out_valid, rd_we, illegal;
    logic [31:0] src1, src2;
    logic [5:0]  alu_control;
    logic [4:0]  shamt, rd;
    logic [15:0] illegal_cnt;

    logic        n_in_ready, n_out_valid, n_rd_we, n_illegal;
    logic [31:0] n_src1, n_src2;
    logic [5:0]  n_alu_control;
    logic [4:0]  n_shamt, n_rd;
    logic [1:0]  n_illegal_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .src1(src1), .src2(src2),
        .alu_control(alu_control), .shamt(shamt), .rd(rd), .rd_we(rd_we),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    alu_decode_stage #(.CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .src1(n_src1), .src2(n_src2),
        .alu_control(n_alu_control), .shamt(n_shamt), .rd(n_rd), .rd_we(n_rd_we),
        .illegal(n_illegal), .illegal_cnt(n_illegal_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] e_src1;
        logic [31:0] e_src2;
        logic [5:0]  e_alu;
        logic [4:0]  e_shamt;
        logic        chk_sh;
        logic [4:0]  e_rd;
        logic        e_we;
        logic        e_ill;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] bp_src1 [4];
        logic [81:0] snap, cur;
        logic        have_snap, acc, drn;
        int          sent, rx;

        vecs[0]  = '{32'h40208133, 32'd10, 32'd3, 32'd10, 32'd3, 6'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0};
        vecs[1]  = '{32'hFFF08093, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 6'd1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0};
        vecs[2]  = '{32'h4042D293, 32'h80000000, 32'd0, 32'h80000000, 32'd4, 6'd9, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0};
        vecs[3]  = '{32'h00000013, 32'd0, 32'd0, 32'd0, 32'd0, 6'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[4]  = '{32'h023100B3, 32'd7, 32'd9, 32'd0, 32'd0, 6'd0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1};
        vecs[5]  = '{32'hFFFFFFFF, 32'd1, 32'd2, 32'd0, 32'd0, 6'd0, 5'd0, 1'b1, 5'd31, 1'b0, 1'b1};
        vecs[6]  = '{32'h123451B7, 32'hDEAD, 32'd5, 32'd0, 32'h12345000, 6'd1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0};
        vecs[7]  = '{32'h002081B3, 32'h100, 32'h25, 32'h100, 32'h25, 6'd1, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0};
        vecs[8]  = '{32'h00209233, 32'hF, 32'h22, 32'hF, 32'h22, 6'd3, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0};
        vecs[9]  = '{32'h4020D2B3, 32'h80000000, 32'd7, 32'h80000000, 32'd7, 6'd9, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0};
        vecs[10] = '{32'h0020B333, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 6'd10, 5'd31, 1'b1, 5'd6, 1'b1, 1'b0};
        vecs[11] = '{32'h40209093, 32'd3, 32'd3, 32'd0, 32'd0, 6'd0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1};
        vecs[12] = '{32'h0F00C393, 32'hAAAA, 32'd0, 32'hAAAA, 32'hF0, 6'd6, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0};
        vecs[13] = '{32'h8000A413, 32'd1, 32'd0, 32'd1, 32'hFFFFF800, 6'd4, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0};
        vecs[14] = '{32'h0020E4B3, 32'h50, 32'h0A, 32'h50, 32'h0A, 6'd5, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0};
        vecs[15] = '{32'h0020F533, 32'hFF, 32'h0F, 32'hFF, 32'h0F, 6'd8, 5'd15, 1'b1, 5'd10, 1'b1, 1'b0};
        vecs[16] = '{32'h0020D5B3, 32'h80, 32'd3, 32'h80, 32'd3, 6'd7, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0};
        vecs[17] = '{32'h4020C633, 32'd1, 32'd1, 32'd0, 32'd0, 6'd0, 5'd0, 1'b1, 5'd12, 1'b0, 1'b1};
        vecs[18] = '{32'h01F09693, 32'd7, 32'd0, 32'd7, 32'd31, 6'd3, 5'd31, 1'b1, 5'd13, 1'b1, 1'b0};

        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_src1", src1, 32'd0);
        chk("rst_alu", {26'd0, alu_control}, 32'd0);
        chk("rst_cnt", {16'd0, illegal_cnt}, 32'd0);

        // Illegal counting and saturation of the 2-bit counter.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h023100B3;
        @(posedge clk); #1;
        chk("mul_illegal", {31'd0, illegal}, 32'd1);
        chk("mul_alu", {26'd0, alu_control}, 32'd0);
        chk("mul_rd_we", {31'd0, rd_we}, 32'd0);
        instr = 32'hFFFFFFFF;
        @(posedge clk); #1;
        chk("ffff_illegal", {31'd0, illegal}, 32'd1);
        chk("cnt_two", {16'd0, illegal_cnt}, 32'd2);
        chk("ncnt_two", {30'd0, n_illegal_cnt}, 32'd2);
        instr = 32'h0000007F;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("cnt_five", {16'd0, illegal_cnt}, 32'd5);
        chk("ncnt_sat", {30'd0, n_illegal_cnt}, 32'd3);

        // Table of single-cycle decodes, streamed back to back.
        for (int i = 0; i < 19; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].instr;
            rs1_data = vecs[i].rs1;
            rs2_data = vecs[i].rs2;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_src1", i), src1, vecs[i].e_src1);
            chk($sformatf("v%0d_src2", i), src2, vecs[i].e_src2);
            chk($sformatf("v%0d_alu", i), {26'd0, alu_control}, {26'd0, vecs[i].e_alu});
            if (vecs[i].chk_sh)
                chk($sformatf("v%0d_shamt", i), {27'd0, shamt}, {27'd0, vecs[i].e_shamt});
            chk($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_rd_we", i), {31'd0, rd_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].e_ill});
        end
        in_valid = 1'b0;
        chk("cnt_after_table", {16'd0, illegal_cnt}, 32'd9);
        chk("ncnt_after_table", {30'd0, n_illegal_cnt}, 32'd3);

        // Backpressure: four bundles, downstream stalled for several cycles.
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 4; k++) bp_src1[k] = 32'h100 + k;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00000093;
        rs1_data  = bp_src1[0];
        sent = 0;
        rx = 0;
        have_snap = 1'b0;
        snap = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 6) begin
                out_ready = 1'b1;
                #1;
                chk("bp_in_ready_reg", {31'd0, in_ready}, 32'd0);
                chk("bp_accepts_stalled", sent, 32'd2);
            end
            cur = {src1, src2, alu_control, shamt, rd, rd_we, illegal};
            if (out_valid && !out_ready) begin
                if (have_snap) chk("bp_stable", {31'd0, cur == snap}, 32'd1);
                else begin
                    snap = cur;
                    have_snap = 1'b1;
                end
            end
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                chk($sformatf("bp_src1_%0d", rx), src1, bp_src1[rx]);
                chk($sformatf("bp_rd_%0d", rx), {27'd0, rd}, rx + 1);
                rx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 4) begin
                    instr    = 32'h00000013 | ((sent + 1) << 7);
                    rs1_data = bp_src1[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (rx == 4) break;
            @(negedge clk);
        end
        chk("bp_rx_count", rx, 32'd4);

        // Asynchronous reset while both entries are occupied.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00000093;
        rs1_data  = 32'h55;
        @(posedge clk); #1;
        instr = 32'h00000113;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_src1", src1, 32'd0);
        chk("arst_rd", {27'd0, rd}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("no_stale_%0d", c), {31'd0, out_valid}, 32'd0);
        end

        // First accept on the first edge after reset release.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        instr    = 32'h123451B7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first_accept_valid", {31'd0, out_valid}, 32'd1);
        chk("first_accept_src2", src2, 32'h12345000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
